fifo_rd_streamer: RTL and testbench
===================================

Name: fifo_rd_streamer

Overview:
Read-side consumer for the dual-clock FIFO. It runs on the FIFO's read clock and drains words using the FIFO's rd_en/empty/rdata port, which has one cycle of read latency. It presents the words downstream as a valid/ready stream, in order, with no loss or duplication. An internal credit-tracked buffer absorbs the read latency and downstream backpressure, so sustained throughput is one word per cycle.

Parameters:
DATA_W, 22, FIFO word width; must match the FIFO WIDTH.
BUF_DEPTH, 3, output buffer entries; minimum 2; 3 or more gives full throughput with no ready-to-rd_en combinational path.
CNT_W, 32, width of the delivered-word counter.

Ports:
clk_i  in  1  FIFO read clock.
rst_ni  in  1  Reset; synchronous, active-low.
enable_i  in  1  Permits new FIFO reads when high.
empty_i  in  1  FIFO empty flag.
rd_en_o  out  1  FIFO read enable.
rdata_i  in  DATA_W  FIFO read data; valid the cycle after rd_en_o is high.
m_valid_o  out  1  Downstream word valid.
m_ready_i  in  1  Downstream ready.
m_data_o  out  DATA_W  Downstream word.
word_cnt_o  out  CNT_W  Count of delivered words (handshakes).
idle_o  out  1  High when the buffer is empty and no read is in flight.

Behaviour:
- Reset, sampled at the clk_i edge with rst_ni=0:
  - occ=0, inflight=0, buffer read/write indices=0.
  - m_valid_o=0, m_data_o=0, word_cnt_o=0, idle_o=1.
  - rd_en_o=0 while rst_ni=0.
- State:
  - occ: buffer occupancy, 0..BUF_DEPTH.
  - inflight: 1 bit, the registered value of rd_en_o.
  - wr_idx, rd_idx: circular indices, modulo BUF_DEPTH.
- Issue rule (combinational, from registered state plus empty_i only): rd_en_o = rst_ni & enable_i & ~empty_i & (occ + inflight < BUF_DEPTH).
- Capture: when inflight=1, rdata_i is written to buf[wr_idx], wr_idx advances and occ increments, at that edge.
- Latency: rd_en_o high in cycle N → data captured at the end of N+1 → m_valid_o high in N+2.
- Output:
  - m_valid_o = (occ != 0); m_data_o = buf[rd_idx], registered from the buffer.
  - While m_valid_o=1 and m_ready_i=0, m_data_o is held stable.
  - When m_valid_o=0, m_data_o is don't-care but is driven with the last value.
- Handshake: m_valid_o & m_ready_i pops one entry; rd_idx advances; word_cnt_o increments, wrapping modulo 2^CNT_W.
- Simultaneous capture and pop: occ is unchanged and both indices advance.
- Overflow never occurs by construction. The credit check counts the in-flight read, so occ + inflight never exceeds BUF_DEPTH.
- enable_i=0: no new reads issue. An in-flight word is still captured, and buffered words still drain.
- empty_i rising: reads stop in the same cycle. An in-flight word is still captured.
- idle_o = (occ == 0) & ~inflight.
- Reset mid-operation: buffered and in-flight words are discarded. Word ordering across reset is undefined, so the FIFO and this block are reset together at system level.
- No state machine beyond the occ/inflight counters. Effective states are IDLE (occ=0, inflight=0), FILLING (inflight=1), HOLDING (occ>0).

Decomposition:
- Package fifo_stream_pkg holds:
  - default DATA_W=22;
  - RD_LATENCY=1 constant;
  - the localparam for the occupancy width, $clog2(BUF_DEPTH+1).
- One sub-module, stream_buf: a circular buffer of BUF_DEPTH x DATA_W with push/pop/occ. fifo_rd_streamer adds the credit/issue logic, the inflight register and the counter.

Test Plan:
- Reset: rst_ni=0 for 2 cycles with empty_i=0 and enable_i=1 → rd_en_o=0, m_valid_o=0, word_cnt_o=0, idle_o=1 throughout.
- Single word: empty_i=0 for cycle N only, rdata_i=22'h155AA in N+1, m_ready_i=1 → m_valid_o=1 with m_data_o=22'h155AA in N+2 only; word_cnt_o=1 afterwards; idle_o=1 in N+3.
- Streaming: 100 words 0..99, empty_i=0, m_ready_i=1 → rd_en_o high every cycle; m_data_o emits 0..99 in consecutive cycles; word_cnt_o=100.
- Backpressure: m_ready_i=0 from the start with the FIFO non-empty → exactly 3 rd_en_o pulses, then rd_en_o=0, occ=3, m_data_o held at the first word. Release m_ready_i → all words delivered in order with none lost.
- enable_i/empty_i gating: deassert enable_i the same cycle as an rd_en_o pulse → that word is still delivered. Toggle empty_i randomly → delivered sequence equals the read sequence.
- Reset mid-stream: assert rst_ni=0 with occ=2 and inflight=1 → next cycle m_valid_o=0, word_cnt_o=0, idle_o=1. With CNT_W=4, 17 handshakes → word_cnt_o=1.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_stream_pkg
// Purpose : Shared constants and helpers for the FIFO read-side streamer.
//           - DEFAULT_DATA_W    : default FIFO word width
//           - DEFAULT_BUF_DEPTH : default output buffer depth
//           - RD_LATENCY        : FIFO read latency (rd_en -> rdata), cycles
//           - occ_width()       : bits needed to hold occupancy 0..depth
// Revision: 1.0 - initial release
// ============================================================================
package fifo_stream_pkg;

  localparam int DEFAULT_DATA_W    = 22;
  localparam int DEFAULT_BUF_DEPTH = 3;

  // The inflight register is a single bit because the FIFO delivers
  // rdata exactly this many cycles after rd_en.
  localparam int RD_LATENCY = 1;

  // Occupancy runs 0..depth inclusive, hence depth+1 codes.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_OCC_W = occ_width(DEFAULT_BUF_DEPTH);

endpackage
`default_nettype wire

// File: rtl/stream_buf.sv
`default_nettype none
// ============================================================================
// Module  : stream_buf
// Purpose : Circular buffer of BUF_DEPTH x DATA_W words with a registered
//           head-of-queue output.
// Ports   : clk_i       - clock
//           rst_ni      - synchronous active-low reset
//           push_i      - write push_data_i at the tail this cycle
//           push_data_i - word to write
//           pop_i       - remove the head entry (ignored when empty)
//           occ_o       - current occupancy, 0..BUF_DEPTH
//           valid_o     - occupancy is non-zero
//           data_o      - registered head entry (holds last value when empty)
// Revision: 1.0 - initial release
// ============================================================================
module stream_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  push_i,
  input  logic [DATA_W-1:0]                     push_data_i,
  input  logic                                  pop_i,
  output logic [occ_width(BUF_DEPTH)-1:0]       occ_o,
  output logic                                  valid_o,
  output logic [DATA_W-1:0]                     data_o
);

  localparam int OCC_W = occ_width(BUF_DEPTH);
  localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [IDX_W-1:0]  r_wr_idx;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [OCC_W-1:0]  r_occ;
  logic [DATA_W-1:0] r_head;

  logic [IDX_W-1:0]  w_wr_idx_nxt;
  logic [IDX_W-1:0]  w_rd_idx_nxt;
  logic [OCC_W-1:0]  w_occ_nxt;
  logic [DATA_W-1:0] w_head_nxt;
  logic              w_pop;

  // Index increment with wrap at BUF_DEPTH (depth need not be a power of 2).
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  assign w_pop = pop_i & (r_occ != '0);

  always_comb begin
    w_wr_idx_nxt = push_i ? idx_inc(r_wr_idx) : r_wr_idx;
    w_rd_idx_nxt = w_pop  ? idx_inc(r_rd_idx) : r_rd_idx;

    w_occ_nxt = r_occ;
    case ({push_i, w_pop})
      2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
      2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
      default: w_occ_nxt = r_occ;
    endcase

    // The head register tracks buf[rd_idx] after this edge. When the only
    // remaining entry is the one being written now, it is not in r_mem yet,
    // so it is forwarded from push_data_i. With nothing left, hold.
    w_head_nxt = r_head;
    if (w_occ_nxt != '0) begin
      if (push_i && (r_occ == OCC_W'(w_pop))) begin
        w_head_nxt = push_data_i;
      end else begin
        w_head_nxt = r_mem[w_rd_idx_nxt];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_occ    <= '0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_head   <= '0;
    end else begin
      r_occ    <= w_occ_nxt;
      r_wr_idx <= w_wr_idx_nxt;
      r_rd_idx <= w_rd_idx_nxt;
      r_head   <= w_head_nxt;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wr_idx] <= push_data_i;
    end
  end

  assign occ_o   = r_occ;
  assign valid_o = (r_occ != '0);
  assign data_o  = r_head;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_streamer
// Purpose : Read-side consumer of a dual-clock FIFO. Issues FIFO reads only
//           when buffer space is guaranteed (credit = occupancy + in-flight
//           read), captures rdata one cycle later and presents the words as
//           an in-order valid/ready stream at up to one word per cycle.
// Ports   : clk_i      - FIFO read clock
//           rst_ni     - synchronous active-low reset
//           enable_i   - permits new FIFO reads
//           empty_i    - FIFO empty flag
//           rd_en_o    - FIFO read enable
//           rdata_i    - FIFO read data, valid the cycle after rd_en_o
//           m_valid_o  - downstream word valid
//           m_ready_i  - downstream ready
//           m_data_o   - downstream word
//           word_cnt_o - delivered-word count (wraps)
//           idle_o     - buffer empty and no read in flight
// Revision: 1.0 - initial release
// ============================================================================
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  parameter int CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              empty_i,
  output logic              rd_en_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic              idle_o
);

  localparam int OCC_W = occ_width(BUF_DEPTH);

  logic [OCC_W-1:0] w_occ;
  logic             w_valid;
  logic             w_pop;
  logic             w_credit_ok;
  logic             w_rd_en;
  logic             r_inflight;
  logic [CNT_W-1:0] r_word_cnt;

  // Credit counts the outstanding read so a word can never arrive without
  // a free slot. Evaluated one bit wider so the sum cannot wrap. Only
  // registered state feeds it, so m_ready_i has no path to rd_en_o.
  assign w_credit_ok = ({1'b0, w_occ} + (OCC_W + 1)'(r_inflight))
                       < (OCC_W + 1)'(BUF_DEPTH);

  assign w_rd_en = rst_ni & enable_i & ~empty_i & w_credit_ok;
  assign w_pop   = w_valid & m_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_inflight <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

  stream_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (r_inflight),
    .push_data_i (rdata_i),
    .pop_i       (w_pop),
    .occ_o       (w_occ),
    .valid_o     (w_valid),
    .data_o      (m_data_o)
  );

  assign rd_en_o    = w_rd_en;
  assign m_valid_o  = w_valid;
  assign word_cnt_o = r_word_cnt;
  assign idle_o     = ~w_valid & ~r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_rd_streamer
// Purpose : Self-checking bench for fifo_rd_streamer. A FIFO source model
//           answers rd_en_o with a word one cycle later; a count-based
//           reference (reads issued / captured / delivered and a queue of
//           read words) predicts every output each cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_rd_streamer;

  localparam int DW    = 22;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enable, empty, m_ready;
  logic [DW-1:0] rdata;
  logic          rd_en, m_valid, idle;
  logic [DW-1:0] m_data;
  logic [31:0]   word_cnt;
  logic          rd_en4, m_valid4, idle4;
  logic [DW-1:0] m_data4;
  logic [3:0]    word_cnt4;

  fifo_rd_streamer #(.DATA_W(DW), .BUF_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .empty_i(empty),
    .rd_en_o(rd_en), .rdata_i(rdata), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_data_o(m_data), .word_cnt_o(word_cnt),
    .idle_o(idle)
  );

  fifo_rd_streamer #(.DATA_W(DW), .BUF_DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .empty_i(empty),
    .rd_en_o(rd_en4), .rdata_i(rdata), .m_valid_o(m_valid4),
    .m_ready_i(m_ready), .m_data_o(m_data4), .word_cnt_o(word_cnt4),
    .idle_o(idle4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int            issued, captured, delivered;
  bit            inflight_m;
  logic [DW-1:0] pend_word;
  logic [DW-1:0] exp_q[$];
  logic [31:0]   exp_cnt;
  logic [DW-1:0] last_out;
  int            rd_pulses;
  int            src_mode;     // 0 random, 1 counter, 2 fixed pattern
  logic [DW-1:0] src_cnt;
  logic [31:0]   cnt_base;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [DW-1:0] next_word();
    logic [DW-1:0] w;
    case (src_mode)
      1: begin w = src_cnt; src_cnt = src_cnt + 1'b1; end
      2: w = 22'h155AA;
      default: w = DW'($urandom);
    endcase
    return w;
  endfunction

  task automatic model_clear();
    issued = 0; captured = 0; delivered = 0;
    inflight_m = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, then
  // advance the reference at the following posedge.
  task automatic step(input logic r, input logic e, input logic em,
                      input logic rdy);
    logic s_rd_en, s_valid;
    bit   exp_rd, exp_valid, exp_idle;
    @(negedge clk);
    rst_n = r; enable = e; empty = em; m_ready = rdy;
    rdata = inflight_m ? pend_word : DW'($urandom);
    #1;
    exp_rd    = r && e && !em && ((issued - delivered) < DEPTH);
    exp_valid = captured > delivered;
    exp_idle  = (issued == delivered);
    check_eq("rd_en", rd_en, exp_rd);
    check_eq("m_valid", m_valid, exp_valid);
    check_eq("idle", idle, exp_idle);
    check_eq("word_cnt", word_cnt, exp_cnt);
    check_eq("rd_en4", rd_en4, exp_rd);
    check_eq("m_valid4", m_valid4, exp_valid);
    check_eq("idle4", idle4, exp_idle);
    check_eq("word_cnt4", word_cnt4, exp_cnt[3:0]);
    if (exp_valid && exp_q.size() > 0) begin
      check_eq("m_data", m_data, exp_q[0]);
      check_eq("m_data4", m_data4, exp_q[0]);
    end
    s_rd_en = rd_en;
    s_valid = m_valid;
    if (s_rd_en) rd_pulses++;
    @(posedge clk);
    if (!r) begin
      model_clear();
    end else begin
      if (inflight_m) captured++;
      if (s_valid && rdy) begin
        delivered++;
        exp_cnt = exp_cnt + 1;
        if (exp_q.size() > 0) last_out = exp_q.pop_front();
      end
      inflight_m = s_rd_en;
      if (s_rd_en) begin
        issued++;
        pend_word = next_word();
        exp_q.push_back(pend_word);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; empty = 1'b0; m_ready = 1'b0; rdata = '0;
    src_mode = 0; src_cnt = '0; rd_pulses = 0; last_out = '0; pend_word = '0;
    model_clear();
    @(posedge clk);

    // Reset held with a non-empty, enabled FIFO
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("rst_m_data", m_data, '0);
    check_eq("rst_idle", idle, 1'b1);

    // Single word
    src_mode = 2;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    src_mode = 0;
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("single_cnt", word_cnt, 32'd1);
    check_eq("single_data", last_out, 22'h155AA);

    // Streaming 0..99 at full rate
    src_mode = 1; src_cnt = '0; rd_pulses = 0; cnt_base = word_cnt;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, (src_cnt >= 100), 1'b1);
    check_eq("stream_rd_pulses", rd_pulses, 100);
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("stream_cnt", word_cnt - cnt_base, 32'd100);
    check_eq("stream_last", last_out, 22'd99);

    // Backpressure: buffer fills to depth, then reads stop
    src_mode = 0; rd_pulses = 0;
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("bp_rd_pulses", rd_pulses, DEPTH);
    check_eq("bp_valid", m_valid, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("bp_drained_idle", idle, 1'b1);

    // enable_i drops right after a read pulse; that word still arrives
    rd_pulses = 0; cnt_base = word_cnt;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("en_rd_pulses", rd_pulses, 1);
    check_eq("en_cnt", word_cnt - cnt_base, 32'd1);

    // Random enable/empty/ready
    for (int i = 0; i < 2000; i++)
      step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0));
    repeat (10) step(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("rand_idle", idle, 1'b1);

    // Reset with occ=2 and a read in flight
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_valid", m_valid, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("midrst_valid", m_valid, 1'b0);
    check_eq("midrst_cnt", word_cnt, 32'd0);
    check_eq("midrst_idle", idle, 1'b1);
    check_eq("midrst_data", m_data, '0);

    // 17 handshakes: 4-bit counter wraps to 1
    rd_pulses = 0;
    for (int i = 0; i < 25; i++) step(1'b1, 1'b1, (rd_pulses >= 17), 1'b1);
    check_eq("wrap_cnt32", word_cnt, 32'd17);
    check_eq("wrap_cnt4", word_cnt4, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
